// File: rtl/popcnt_frame_arb.sv
// popcnt_frame_arb: round-robin scheduler for a shared 32-bit ones/zeros counter.
// It grants one of two requesters a whole frame of len words, accumulates
// the popcount of each accepted word, and returns the frame totals through a
// held result handshake.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req[1:0]           : per-requester frame request, held until grant
//   len0/len1          : frame length in words per requester
//   din0/din1, valid0/1: per-requester data stream
//   ready0/ready1      : data accept, only the owner's ready is ever high
//   grant[1:0]         : one-hot, one-cycle pulse at start of service
//   busy               : high in every state except IDLE
//   res_valid/res_ready: result handshake; res_id/res_ones/res_zeros held until taken
module popcnt_frame_arb #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CW    = LEN_W + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [31:0]      din0,
  input  logic [31:0]      din1,
  input  logic             valid0,
  input  logic             valid1,
  output logic             ready0,
  output logic             ready1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic [CW-1:0]    res_ones,
  output logic [CW-1:0]    res_zeros,
  input  logic             res_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             own_q, own_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [1:0]       ready_q, ready_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [CW-1:0]    res_ones_q, res_ones_d;
  logic [CW-1:0]    res_zeros_q, res_zeros_d;

  logic             sel_c;
  logic [LEN_W-1:0] sel_len_c;
  logic [31:0]      own_din_c;
  logic             own_valid_c;
  logic             beat_c;
  logic             last_c;
  logic [CW-1:0]    acc_sum_c;

  // Number of set bits in a 32-bit word (0..32).
  function automatic logic [5:0] popcnt32(input logic [31:0] w);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < 32; i++) begin
      s = s + 6'(w[i]);
    end
    return s;
  endfunction

  // Zero bits in the frame: len*32 - ones, computed at full result width.
  function automatic logic [CW-1:0] zeros_of(input logic [LEN_W-1:0] l,
                                             input logic [CW-1:0]    a);
    return (CW'(l) << 5) - a;
  endfunction

  // Arbitration and datapath helpers.
  always_comb begin
    sel_c       = (req == 2'b11) ? rr_q : req[1];
    sel_len_c   = sel_c ? len1 : len0;
    own_din_c   = own_q ? din1 : din0;
    own_valid_c = own_q ? valid1 : valid0;
    beat_c      = (state_q == RUN) && own_valid_c && ready_q[own_q];
    last_c      = beat_c && (remain_q == LEN_W'(1));
    acc_sum_c   = acc_q + CW'(popcnt32(own_din_c));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    own_d       = own_q;
    remain_d    = remain_q;
    len_d       = len_q;
    acc_d       = acc_q;
    ready_d     = 2'b00;
    grant_d     = 2'b00;
    res_valid_d = 1'b0;
    res_id_d    = 1'b0;
    res_ones_d  = '0;
    res_zeros_d = '0;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          own_d    = sel_c;
          len_d    = sel_len_c;
          remain_d = sel_len_c;
          acc_d    = '0;
          grant_d  = sel_c ? 2'b10 : 2'b01;
          if (sel_len_c != '0) begin
            state_d = RUN;
            ready_d = sel_c ? 2'b10 : 2'b01;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (beat_c) begin
          acc_d    = acc_sum_c;
          remain_d = remain_q - LEN_W'(1);
        end
        // The last beat loads the result directly so it appears next cycle.
        if (last_c) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_id_d    = own_q;
          res_ones_d  = acc_sum_c;
          res_zeros_d = zeros_of(len_q, acc_sum_c);
        end else begin
          ready_d = own_q ? 2'b10 : 2'b01;
        end
      end
      DONE: begin
        // A zero-length frame enters with res_valid low and raises it here.
        if (res_valid_q && res_ready) begin
          rr_d    = ~own_q;
          state_d = IDLE;
        end else begin
          res_valid_d = 1'b1;
          res_id_d    = own_q;
          res_ones_d  = acc_q;
          res_zeros_d = zeros_of(len_q, acc_q);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      own_q       <= 1'b0;
      remain_q    <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      ready_q     <= 2'b00;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_ones_q  <= '0;
      res_zeros_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      own_q       <= own_d;
      remain_q    <= remain_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      ready_q     <= ready_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_ones_q  <= res_ones_d;
      res_zeros_q <= res_zeros_d;
    end
  end

  assign ready0    = ready_q[0];
  assign ready1    = ready_q[1];
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_ones  = res_ones_q;
  assign res_zeros = res_zeros_q;

endmodule

// File: tb/tb_popcnt_frame_arb.sv
// Scoreboard bench for popcnt_frame_arb: directed frames push expected
// results into a queue; a negedge monitor pops and compares on each
// result handshake.
module tb_popcnt_frame_arb;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned CW    = 14;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [LEN_W-1:0] len0, len1;
  logic [31:0]      din0, din1;
  logic             valid0, valid1;
  logic             ready0, ready1;
  logic [1:0]       grant;
  logic             busy;
  logic             res_valid, res_id;
  logic [CW-1:0]    res_ones, res_zeros;
  logic             res_ready;

  always #5 clk = ~clk;

  popcnt_frame_arb #(.LEN_W(LEN_W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1),
    .din0(din0), .din1(din1), .valid0(valid0), .valid1(valid1),
    .ready0(ready0), .ready1(ready1), .grant(grant), .busy(busy),
    .res_valid(res_valid), .res_id(res_id), .res_ones(res_ones),
    .res_zeros(res_zeros), .res_ready(res_ready)
  );

  typedef struct packed {
    logic          id;
    logic [CW-1:0] ones;
    logic [CW-1:0] zeros;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_res = 0;

  logic [31:0] q0[$], q1[$];
  bit          tog0 = 1'b0;
  bit          ph   = 1'b0;
  bit          hs0  = 1'b0;
  bit          hs1  = 1'b0;
  int          beats0 = 0;
  int          beats1 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Handshakes observed mid-cycle, consumed by the source driver.
  always @(negedge clk) begin
    hs0 = rst_n && valid0 && ready0;
    hs1 = rst_n && valid1 && ready1;
  end

  // Word sources: present queue heads, pop on accepted beats.
  always begin
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) begin
      void'(q0.pop_front());
      beats0++;
    end
    if (hs1 && q1.size() > 0) begin
      void'(q1.pop_front());
      beats1++;
    end
    ph = ~ph;
    if (q0.size() > 0) begin
      din0   = q0[0];
      valid0 = tog0 ? ph : 1'b1;
    end else begin
      din0   = 32'h0;
      valid0 = 1'b0;
    end
    if (q1.size() > 0) begin
      din1   = q1[0];
      valid1 = 1'b1;
    end else begin
      din1   = 32'h0;
      valid1 = 1'b0;
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got result id=%0d ones=%0d with empty scoreboard", res_id, res_ones);
      end else begin
        mon_e = sb.pop_front();
        check("res_id", 64'(res_id), 64'(mon_e.id));
        check("res_ones", 64'(res_ones), 64'(mon_e.ones));
        check("res_zeros", 64'(res_zeros), 64'(mon_e.zeros));
        n_res++;
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check(nm, {ready0, ready1, grant, busy, res_valid, res_id, res_ones, res_zeros}, '0);
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string nm, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant == 2'b00 && k < 50);
    check(nm, 64'(grant), 64'(exp));
  endtask

  // Runs until res_valid; counts cycles with a stray grant, the non-owner's
  // ready, or the owner's ready not matching the expected level.
  task automatic wait_res(input logic id, input bit own_rdy, output int cyc, output int bad);
    logic r_own, r_oth;
    cyc = 0;
    bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      r_own = id ? ready1 : ready0;
      r_oth = id ? ready0 : ready1;
      if (grant != 2'b00 || r_oth || (r_own != (own_rdy && !res_valid))) bad++;
    end while (!res_valid && cyc < 600);
    check("res_valid_seen", 64'(res_valid), 64'd1);
  endtask

  task automatic frame(input logic id, input logic [LEN_W-1:0] len,
                       input logic [CW-1:0] ones, input logic [CW-1:0] zeros,
                       input int lat);
    int k, cyc, bad, b;
    sb.push_back('{id: id, ones: ones, zeros: zeros});
    if (id) len1 = len; else len0 = len;
    req[id] = 1'b1;
    wait_grant(id ? 2'b10 : 2'b01, "grant", k);
    check("grant_cycle_io", {busy, ready1, ready0},
          {1'b1, id && (len != 0), !id && (len != 0)});
    req[id] = 1'b0;
    b = id ? beats1 : beats0;
    wait_res(id, len != 0, cyc, bad);
    check("frame_handshake_bad_cycles", 64'(bad), 64'd0);
    if (lat >= 0) check("result_latency", 64'(cyc), 64'(lat));
    check("beats", 64'((id ? beats1 : beats0) - b), 64'(len));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, cyc, bad, b;
    rst_n = 1'b0; req = 2'b00; len0 = '0; len1 = '0; res_ready = 1'b1;
    din0 = '0; din1 = '0; valid0 = 1'b0; valid1 = 1'b0;
    do_reset();

    // Single frame: 32 + 0 + 4 ones over 3 words.
    q0 = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_000F};
    frame(1'b0, 8'd3, 14'd36, 14'd60, 3);
    @(negedge clk);
    check("res_valid_pulse_and_idle", {res_valid, busy}, 2'b00);

    // Contention from reset: requester 0 first, then requester 1.
    do_reset();
    q0 = '{32'h0000_0003, 32'h0000_00FF};
    q1 = '{32'hF0F0_F0F0, 32'h0001_0000};
    len0 = 8'd2; len1 = 8'd2;
    sb.push_back('{id: 1'b0, ones: 14'd10, zeros: 14'd54});
    sb.push_back('{id: 1'b1, ones: 14'd17, zeros: 14'd47});
    req = 2'b11;
    wait_grant(2'b01, "contention_grant0", k);
    req[0] = 1'b0;
    wait_res(1'b0, 1'b1, cyc, bad);
    check("contention_frame0_no_grant1_no_ready1", 64'(bad), 64'd0);
    wait_grant(2'b10, "contention_grant1", k);
    check("inter_frame_gap", 64'(k), 64'd2);
    req[1] = 1'b0;
    wait_res(1'b1, 1'b1, cyc, bad);
    check("contention_frame1_bad_cycles", 64'(bad), 64'd0);

    // Toggling valid: ready stays up, exactly 2 beats counted.
    tog0 = 1'b1;
    q0 = '{32'h0000_FFFF, 32'h0000_0001};
    frame(1'b0, 8'd2, 14'd17, 14'd47, -1);
    tog0 = 1'b0;

    // Result held while res_ready is low.
    @(posedge clk); #2 res_ready = 1'b0;
    q0 = '{32'h1234_5678};
    @(negedge clk);
    frame(1'b0, 8'd1, 14'd13, 14'd19, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("result_hold", {res_valid, res_id, res_ones, res_zeros},
            {1'b1, 1'b0, 14'd13, 14'd19});
    end
    @(posedge clk); #2 res_ready = 1'b1;
    @(negedge clk);

    // Zero-length frame on requester 1.
    frame(1'b1, 8'd0, 14'd0, 14'd0, 1);

    // Maximum frame of all-ones words.
    for (int i = 0; i < 255; i++) q0.push_back(32'hFFFF_FFFF);
    frame(1'b0, 8'd255, 14'd8160, 14'd0, 255);

    // Reset after 2 of 4 beats discards the frame.
    repeat (2) @(negedge clk);
    q0 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    len0 = 8'd4;
    req = 2'b01;
    wait_grant(2'b01, "abort_grant", k);
    req = 2'b00;
    b = beats0;
    k = 0;
    while (beats0 - b < 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort_beats_before_reset", 64'(beats0 - b), 64'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_frame_reset_outputs");
    q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q0 = '{32'h8000_0001};
    frame(1'b0, 8'd1, 14'd2, 14'd30, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("results_seen", 64'(n_res), 64'd8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
